// File: rtl/add_pkg.sv
// Shared definitions for the chunked pipelined adder: operation encodings
// and the stage-count helper used by the top level.
package add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its top
// bit so the final slice can derive signed overflow.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    // Sum bit = a ^ b ^ carry-in, so the carry-in is recovered by XOR.
    c_msb   = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
  end

endmodule

// File: rtl/add_pipe_n.sv
// WIDTH-bit adder/subtractor pipelined as WIDTH/CHUNK carry-ripple stages
// with valid/ready flow control and a single global stall.
module add_pipe_n
  import add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_width
    $error("add_pipe_n: WIDTH must be a positive multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             c_in  [STAGES];
  logic             vld_in[STAGES];

  logic [CHUNK-1:0] ch_s   [STAGES];
  logic             ch_co  [STAGES];
  logic             ch_msb [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [STAGES-1:0] vld_q, vld_d, c_q, c_d;
  logic             ov_q, ov_d;

  // Stage inputs: stage 0 takes the ports, stage k takes stage k-1 registers.
  always_comb begin
    advance = !vld_q[LAST] || out_ready;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_d[k]    = A;
        b_d[k]    = (SUB == MODE_SUB) ? ~B : B;
        s_in[k]   = '0;
        c_in[k]   = CI;
        vld_in[k] = in_valid;
      end else begin
        a_d[k]    = a_q[k-1];
        b_d[k]    = b_q[k-1];
        s_in[k]   = s_q[k-1];
        c_in[k]   = c_q[k-1];
        vld_in[k] = vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_d[k][k*CHUNK +: CHUNK]),
      .b     (b_d[k][k*CHUNK +: CHUNK]),
      .ci    (c_in[k]),
      .s     (ch_s[k]),
      .co    (ch_co[k]),
      .c_msb (ch_msb[k])
    );
  end

  // Each stage drops its finished chunk into the travelling partial sum.
  always_comb begin
    vld_d = '0;
    c_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k]                   = s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = ch_s[k];
      c_d[k]                   = ch_co[k];
      vld_d[k]                 = vld_in[k];
    end
    ov_d = ch_msb[LAST] ^ ch_co[LAST];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ov_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) s_q[k] <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      ov_q  <= ov_d;
      for (int k = 0; k < STAGES; k++) s_q[k] <= s_d[k];
    end
  end

  // Operand bits are pure data; stale values behind an invalid stage are harmless.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign S         = s_q[LAST];
  assign CO        = c_q[LAST];
  assign OV        = ov_q;

endmodule

// File: tb/tb_add_pipe_n.sv
// Directed + randomized bench for add_pipe_n (WIDTH=32, CHUNK=8) against an
// arithmetic reference model and an in-order expectation queue.
module tb_add_pipe_n;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, CI, SUB;
  logic             out_valid, out_ready, CO, OV;
  logic [WIDTH-1:0] A, B, S;

  always #5 clk = ~clk;

  add_pipe_n #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CI        (CI),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .CO        (CO),
    .OV        (OV)
  );

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  bit   chk_lat  = 1'b0;
  int   base;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub, input int when);
    exp_t        r;
    logic [32:0] full;
    logic [31:0] bx;
    bx    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bx} + {32'd0, ci};
    r.s   = full[31:0];
    r.co  = full[32];
    r.ov  = (a[31] == bx[31]) && (full[31] != a[31]);
    r.acc = when;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("no_spurious_out", {63'd0, (out_valid && q.size() == 0)}, 64'd0);
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("S", {32'd0, S}, {32'd0, e.s});
      chk("CO", {63'd0, CO}, {63'd0, e.co});
      chk("OV", {63'd0, OV}, {63'd0, e.ov});
      if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(LAT));
      n_out++;
    end
    if (in_valid && in_ready) q.push_back(model(A, B, CI, SUB, cyc));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub);
    in_valid = 1'b1; A = a; B = b; CI = ci; SUB = sub;
  endtask

  task automatic rand_beat();
    beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input int bound);
    in_valid = 1'b0;
    for (int i = 0; i < bound && q.size() > 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; CI = 1'b0; SUB = 1'b0;

    // Asynchronous reset, before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_S", {32'd0, S}, 64'd0);
    chk("rst_CO", {63'd0, CO}, 64'd0);
    chk("rst_OV", {63'd0, OV}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Full carry ripple through every stage.
    chk_lat = 1'b1;
    beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    chk("ripple_vld", {63'd0, out_valid}, 64'd1);
    chk("ripple_S", {32'd0, S}, 64'h0);
    chk("ripple_CO", {63'd0, CO}, 64'd1);
    chk("ripple_OV", {63'd0, OV}, 64'd0);
    drain(10);

    // Signed overflow, then subtraction with borrow-complement CI=1.
    beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick();
    beat(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("ovf_S", {32'd0, S}, 64'h8000_0000);
    chk("ovf_CO", {63'd0, CO}, 64'd0);
    chk("ovf_OV", {63'd0, OV}, 64'd1);
    tick();
    chk("sub_vld", {63'd0, out_valid}, 64'd1);
    chk("sub_S", {32'd0, S}, 64'hFFFF_FFFE);
    chk("sub_CO", {63'd0, CO}, 64'd0);
    chk("sub_OV", {63'd0, OV}, 64'd0);
    drain(10);

    // 16 back-to-back random beats.
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      rand_beat();
      tick();
    end
    drain(20);
    chk("b2b_count", 64'(n_out - base), 64'd16);

    // Backpressure: fill, stall 5 cycles, then drain.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    base      = n_out;
    for (int i = 0; i < LAT; i++) begin
      rand_beat();
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_vld", {63'd0, out_valid}, 64'd1);
      chk("stall_S", {32'd0, S}, {32'd0, q[0].s});
      chk("stall_CO", {63'd0, CO}, {63'd0, q[0].co});
      chk("stall_OV", {63'd0, OV}, {63'd0, q[0].ov});
      tick();
    end
    out_ready = 1'b1;
    drain(20);
    chk("stall_count", 64'(n_out - base), 64'(LAT));

    // Alternating bubbles.
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("bubble_vld", {63'd0, out_valid}, {63'd0, (i >= LAT && ((i - LAT) % 2) == 0)});
      if ((i % 2) == 0) rand_beat();
      else in_valid = 1'b0;
      tick();
    end
    drain(20);

    // Reset with beats in flight.
    chk_lat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_rst_vld", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_S", {32'd0, S}, 64'd0);
    chk("mid_rst_CO", {63'd0, CO}, 64'd0);
    chk("mid_rst_OV", {63'd0, OV}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_lat = 1'b1;
    beat(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    tick();
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_pipe_n.md
ADD_PIPE_N -- requirements
Module: add_pipe_n

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK, at least 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 B  input  WIDTH  operand B.
REQ-009 CI  input  1  carry-in (add) / borrow-in complement (sub).
REQ-010 SUB  input  1  0 = A+B+CI, 1 = A+~B+CI.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 S  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 CO  output  1  carry-out of bit WIDTH-1.
REQ-015 OV  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-016 Pipeline SHALL have STAGES registered stages; stage k adds bits [k*CHUNK +: CHUNK] with the carry registered from stage k-1 (stage 0 uses CI).
REQ-017 Operand bits not yet consumed SHALL travel with the beat; completed sum chunks SHALL be carried forward so S is assembled at the last stage.
REQ-018 SUB SHALL be applied at stage 0 input by inverting B; CI is used unchanged (SUB=1, CI=1 gives A-B).
REQ-019 Latency SHALL be exactly STAGES cycles from accepted beat to out_valid with no backpressure; throughput one beat per cycle.
REQ-020 Beat accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-021 advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational); when advance=0 every stage holds.
REQ-022 Each stage SHALL carry a valid bit; bubbles propagate as invalid and never produce out_valid.
REQ-023 S, CO, OV SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous accept and consume in one cycle SHALL both occur; no beat is lost or duplicated.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 OV SHALL be computed in the last stage from its carry-in to bit WIDTH-1 and CO.
REQ-027 STAGES=1 SHALL degenerate to one registered full-width adder with latency 1.

Reset
REQ-028 While rst=1 all stage valid bits, out_valid, S, CO, OV SHALL be 0 immediately, independent of clk.
REQ-029 Beats in flight when rst asserts SHALL be discarded; after release first accept occurs on first edge with in_valid=1.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).

Structure
REQ-031 Shared package add_pkg SHALL hold MODE_ADD=0, MODE_SUB=1 and a function computing STAGES.
REQ-032 One sub-module add_chunk SHALL implement the combinational CHUNK-bit adder (a, b, ci -> s, co, c_msb), instantiated once per stage.
REQ-033 Elaboration SHALL fail if WIDTH mod CHUNK is nonzero.

Verification (WIDTH=32, CHUNK=8, latency 4)
REQ-034 Reset mid-stream: 3 beats in flight, pulse rst asynchronously -> out_valid=0 at once, no stale result after release.
REQ-035 A=FFFFFFFF, B=00000001, CI=0, SUB=0 -> 4 cycles later S=00000000, CO=1, OV=0 (full carry ripple across all stages).
REQ-036 A=7FFFFFFF, B=00000001, SUB=0 -> S=80000000, CO=0, OV=1; A=00000005, B=00000007, SUB=1, CI=1 -> S=FFFFFFFE, CO=0, OV=0.
REQ-037 Back-to-back 16 random beats, out_ready=1 -> 16 correct results on consecutive cycles, in order, first at cycle 4.
REQ-038 out_ready=0 for 5 cycles with full pipeline -> in_ready=0, S/CO/OV held; out_ready=1 -> all beats drain in order, none lost.
REQ-039 in_valid toggled every other cycle -> bubbles preserved, out_valid alternates, results match model.
